// File: rtl/mem_stage_p.sv
// Memory-access pipeline stage: little-endian byte memory with sized loads/stores,
// programmable wait states with upstream stall, and the stage-4 to stage-5 register.
module mem_stage_p #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 8,
  parameter int WAIT_CYC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid4,
  input  logic [DATA_W-1:0] ir4,
  input  logic [DATA_W-1:0] pc4,
  input  logic [DATA_W-1:0] z4,
  input  logic [DATA_W-1:0] s4,
  input  logic              mem_to_reg4,
  input  logic              mem_read4,
  input  logic              mem_write4,
  input  logic              reg_write4,
  input  logic              jal4,
  input  logic [1:0]        size4,
  input  logic              unsigned4,
  input  logic              fwd_sw_mem,
  output logic [DATA_W-1:0] s4_fwd,
  output logic              stall,
  output logic [DATA_W-1:0] z5,
  output logic [DATA_W-1:0] ir5,
  output logic              reg_write5,
  output logic              valid5,
  output logic              fault5
);

  localparam int NB = DATA_W / 8;
  localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYC == 0) ? 0 : WAIT_CYC - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [7:0]        mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] addr;
  logic              access, misaligned, fault, aligned, do_write;
  logic [DATA_W-1:0] raw, load_data, wb_value;
  logic              sign;
  int                lbits, nbytes;
  logic              unused_z4;

  assign addr      = z4[ADDR_W-1:0];
  assign unused_z4 = ^z4[DATA_W-1:ADDR_W];
  assign s4_fwd    = fwd_sw_mem ? z5 : s4;
  assign access    = valid4 & (mem_read4 | mem_write4);
  assign fault     = access & misaligned;
  assign aligned   = access & ~misaligned;
  assign nbytes    = 1 << int'(size4);

  always_comb begin
    misaligned = 1'b0;
    case (size4)
      2'b01:   misaligned = addr[0];
      2'b10:   misaligned = addr[1:0] != 2'b00;
      2'b11:   misaligned = (DATA_W == 32) || (addr[2:0] != 3'b000);
      default: misaligned = 1'b0;
    endcase
  end

  // Stall is gated by reset so an aborted wait releases upstream immediately.
  assign stall = rst_n & (((state == IDLE) & aligned & (WAIT_CYC != 0)) |
                          ((state == WAIT) & (cnt != 4'd0)));
  assign do_write = rst_n & aligned & mem_write4 & ~mem_read4 & ~stall;

  always_comb begin
    raw = '0;
    for (int i = 0; i < NB; i++) raw[8*i +: 8] = mem[addr + ADDR_W'(i)];
  end

  always_comb begin
    lbits = 8 << int'(size4);
    case (size4)
      2'b00:   sign = raw[7];
      2'b01:   sign = raw[15];
      2'b10:   sign = raw[31];
      default: sign = raw[DATA_W-1];
    endcase
    load_data = raw;
    for (int b = 0; b < DATA_W; b++)
      if (b >= lbits) load_data[b] = sign & ~unsigned4;
  end

  assign wb_value = mem_to_reg4 ? load_data : (jal4 ? pc4 : z4);

  always_ff @(posedge clk) begin
    if (do_write)
      for (int i = 0; i < NB; i++)
        if (i < nbytes) mem[addr + ADDR_W'(i)] <= s4_fwd[8*i +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: if (aligned && (WAIT_CYC != 0)) begin
          state <= WAIT;
          cnt   <= WAIT_INIT;
        end
        WAIT: if (cnt != 4'd0) cnt <= cnt - 4'd1;
              else             state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stalled cycles push a bubble; z5/ir5 hold so forwarded store data stays put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z5         <= '0;
      ir5        <= '0;
      reg_write5 <= 1'b0;
      valid5     <= 1'b0;
      fault5     <= 1'b0;
    end else if (stall) begin
      reg_write5 <= 1'b0;
      valid5     <= 1'b0;
      fault5     <= 1'b0;
    end else begin
      z5         <= fault ? '0 : wb_value;
      ir5        <= ir4;
      reg_write5 <= valid4 & reg_write4 & ~fault;
      valid5     <= valid4;
      fault5     <= fault;
    end
  end

endmodule

// File: tb/tb_mem_stage_p.sv
// Bench for mem_stage_p: a 32-bit/3-wait instance and a 64-bit/0-wait instance
// share stimulus and are checked each cycle against a byte-array reference model.
module tb_mem_stage_p;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid4 = 0, mem_to_reg4 = 0, mem_read4 = 0, mem_write4 = 0;
  logic        reg_write4 = 0, jal4 = 0, unsigned4 = 0, fwd_sw_mem = 0;
  logic [1:0]  size4 = 0;
  logic [63:0] ir4 = 0, pc4 = 0, z4 = 0, s4 = 0;

  logic [31:0] s4_fwd_a, z5_a, ir5_a;
  logic        stall_a, reg_write5_a, valid5_a, fault5_a;
  logic [63:0] s4_fwd_b, z5_b, ir5_b;
  logic        stall_b, reg_write5_b, valid5_b, fault5_b;

  int vectors = 0, miscompares = 0;
  bit chk_en = 0;
  int stall_seen;
  logic [63:0] sfwd_seen;

  // Reference state: one byte array and one stage-5 snapshot per instance.
  logic [7:0]  mem_m [2][256];
  logic [63:0] z5_m [2], ir5_m [2];
  logic [63:0] e_sfwd [2], e_z5 [2], e_ir5 [2];
  logic        e_stall [2], e_v5 [2], e_rw5 [2], e_f5 [2];

  always #5 clk = ~clk;

  mem_stage_p #(.DATA_W(32), .ADDR_W(8), .WAIT_CYC(3)) u32 (
    .clk(clk), .rst_n(rst_n), .valid4(valid4), .ir4(ir4[31:0]), .pc4(pc4[31:0]),
    .z4(z4[31:0]), .s4(s4[31:0]), .mem_to_reg4(mem_to_reg4), .mem_read4(mem_read4),
    .mem_write4(mem_write4), .reg_write4(reg_write4), .jal4(jal4), .size4(size4),
    .unsigned4(unsigned4), .fwd_sw_mem(fwd_sw_mem), .s4_fwd(s4_fwd_a), .stall(stall_a),
    .z5(z5_a), .ir5(ir5_a), .reg_write5(reg_write5_a), .valid5(valid5_a), .fault5(fault5_a));

  mem_stage_p #(.DATA_W(64), .ADDR_W(8), .WAIT_CYC(0)) u64 (
    .clk(clk), .rst_n(rst_n), .valid4(valid4), .ir4(ir4), .pc4(pc4),
    .z4(z4), .s4(s4), .mem_to_reg4(mem_to_reg4), .mem_read4(mem_read4),
    .mem_write4(mem_write4), .reg_write4(reg_write4), .jal4(jal4), .size4(size4),
    .unsigned4(unsigned4), .fwd_sw_mem(fwd_sw_mem), .s4_fwd(s4_fwd_b), .stall(stall_b),
    .z5(z5_b), .ir5(ir5_b), .reg_write5(reg_write5_b), .valid5(valid5_b), .fault5(fault5_b));

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit misFn(input int dw, input logic [1:0] sz, input logic [7:0] a);
    case (sz)
      2'b01:   return a[0];
      2'b10:   return a[1:0] != 2'b00;
      2'b11:   return (dw == 32) || (a[2:0] != 3'b000);
      default: return 1'b0;
    endcase
  endfunction

  // Predicts both instances for cycle c of the current presentation.
  task automatic modelStep(input int c);
    for (int k = 0; k < 2; k++) begin
      int dw = k ? 64 : 32;
      int wc = k ? 0 : 3;
      logic [63:0] mask = k ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      logic [7:0]  a = z4[7:0];
      int          n = 1 << int'(size4);
      bit          acc = valid4 && (mem_read4 || mem_write4);
      bit          mis = acc && misFn(dw, size4, a);
      logic [63:0] sfwd = (fwd_sw_mem ? z5_m[k] : s4) & mask;
      logic [63:0] ld = 0, z;
      e_sfwd[k]  = sfwd;
      e_stall[k] = acc && !mis && (c < wc);
      if (e_stall[k]) begin
        e_v5[k] = 0; e_rw5[k] = 0; e_f5[k] = 0;
        e_z5[k] = z5_m[k]; e_ir5[k] = ir5_m[k];
      end else begin
        for (int i = 0; i < n; i++) ld |= 64'(mem_m[k][8'(a + 8'(i))]) << (8 * i);
        if (!unsigned4 && n < 8 && ld[8*n-1]) ld |= ~((64'd1 << (8 * n)) - 64'd1);
        z = mis ? 64'd0 : (mem_to_reg4 ? ld : (jal4 ? pc4 : z4));
        z = z & mask;
        e_z5[k] = z; e_ir5[k] = ir4 & mask;
        e_v5[k] = valid4; e_rw5[k] = valid4 && reg_write4 && !mis; e_f5[k] = mis;
        if (acc && !mis && mem_write4 && !mem_read4)
          for (int i = 0; i < n; i++) mem_m[k][8'(a + 8'(i))] = 8'(sfwd >> (8 * i));
        z5_m[k] = z; ir5_m[k] = e_ir5[k];
      end
    end
  endtask

  // Single compare process: combinational outputs mid-cycle, registered ones after the edge.
  initial begin
    forever begin
      @(negedge clk); #2;
      if (chk_en) begin
        checkOutput("stall32", stall_a, e_stall[0]);
        checkOutput("sfwd32", s4_fwd_a, e_sfwd[0]);
        checkOutput("stall64", stall_b, e_stall[1]);
        checkOutput("sfwd64", s4_fwd_b, e_sfwd[1]);
      end
      @(posedge clk); #1;
      if (chk_en) begin
        checkOutput("z5_32", z5_a, e_z5[0]);
        checkOutput("ir5_32", ir5_a, e_ir5[0]);
        checkOutput("v5_32", valid5_a, e_v5[0]);
        checkOutput("rw5_32", reg_write5_a, e_rw5[0]);
        checkOutput("f5_32", fault5_a, e_f5[0]);
        checkOutput("z5_64", z5_b, e_z5[1]);
        checkOutput("ir5_64", ir5_b, e_ir5[1]);
        checkOutput("v5_64", valid5_b, e_v5[1]);
        checkOutput("rw5_64", reg_write5_b, e_rw5[1]);
        checkOutput("f5_64", fault5_b, e_f5[1]);
      end
    end
  end

  // Presents one instruction, held for as long as the 32-bit instance needs it;
  // abort_c >= 0 pulls reset at that cycle of the presentation instead.
  task automatic applyStimulus(input bit v, rd, wr, m2r, rw, jal, uns, fwd,
                               input logic [1:0] sz, input logic [63:0] z, s, pc, ir,
                               input int abort_c = -1);
    bit acc_ok = v && (rd || wr) && !misFn(32, sz, z[7:0]);
    int ncyc = acc_ok ? 4 : 1;
    stall_seen = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (c == abort_c) begin
        chk_en = 0;
        rst_n = 0;
        #1;
        checkOutput("rst_stall32", stall_a, 0);
        checkOutput("rst_z5_32", z5_a, 0);
        checkOutput("rst_ir5_32", ir5_a, 0);
        checkOutput("rst_v5_32", valid5_a, 0);
        checkOutput("rst_rw5_32", reg_write5_a, 0);
        checkOutput("rst_f5_32", fault5_a, 0);
        checkOutput("rst_z5_64", z5_b, 0);
        @(posedge clk);
        @(negedge clk);
        {valid4, mem_read4, mem_write4, mem_to_reg4, reg_write4, jal4, fwd_sw_mem} = '0;
        z4 = 0; ir4 = 0; pc4 = 0; s4 = 0;
        rst_n = 1;
        for (int k = 0; k < 2; k++) begin z5_m[k] = 0; ir5_m[k] = 0; end
        @(posedge clk); #2;
        return;
      end
      valid4 = v; mem_read4 = rd; mem_write4 = wr; mem_to_reg4 = m2r; reg_write4 = rw;
      jal4 = jal; unsigned4 = uns; fwd_sw_mem = fwd; size4 = sz;
      z4 = z; s4 = s; pc4 = pc; ir4 = ir;
      modelStep(c);
      chk_en = 1;
      #2;
      if (c == 0) sfwd_seen = 64'(s4_fwd_a);
      if (stall_a) stall_seen++;
    end
    @(posedge clk); #2;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin z5_m[k] = 0; ir5_m[k] = 0; end
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1;

    // Fill memory with known data so every later load is defined.
    for (int i = 0; i < 64; i++)
      applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 2'b10, 64'(i * 4), {$urandom, $urandom},
                    64'($urandom), 64'($urandom));

    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 2'b10, 64'h10, 64'hDEADBEEF, 0, 64'h11);
    applyStimulus(1, 1, 0, 1, 1, 0, 0, 0, 2'b10, 64'h10, 0, 0, 64'h12);
    checkOutput("ldw_lit32", z5_a, 32'hDEADBEEF);
    checkOutput("ldw_rw_lit32", reg_write5_a, 1);
    checkOutput("ldw_lit64", z5_b, 64'hFFFF_FFFF_DEAD_BEEF);
    checkOutput("wait_stalls", stall_seen, 3);

    applyStimulus(1, 1, 0, 1, 1, 0, 0, 0, 2'b00, 64'h13, 0, 0, 64'h13);
    checkOutput("ldb_s_lit32", z5_a, 32'hFFFFFFDE);
    checkOutput("ldb_s_lit64", z5_b, 64'hFFFF_FFFF_FFFF_FFDE);
    applyStimulus(1, 1, 0, 1, 1, 0, 1, 0, 2'b00, 64'h13, 0, 0, 64'h14);
    checkOutput("ldb_u_lit32", z5_a, 32'h000000DE);

    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 2'b10, 64'h20, 64'hAAAAAAAA, 0, 64'h20);
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 2'b01, 64'h20, 64'h1234, 0, 64'h21);
    applyStimulus(1, 1, 0, 1, 1, 0, 1, 0, 2'b10, 64'h20, 0, 0, 64'h22);
    checkOutput("sth_lit32", z5_a, 32'hAAAA1234);
    checkOutput("sth_lit64", z5_b, 64'h0000_0000_AAAA_1234);
    applyStimulus(1, 0, 1, 0, 1, 0, 0, 0, 2'b01, 64'h21, 64'h5678, 0, 64'h23);
    checkOutput("mis_f5_32", fault5_a, 1);
    checkOutput("mis_rw5_32", reg_write5_a, 0);
    checkOutput("mis_z5_32", z5_a, 0);
    checkOutput("mis_f5_64", fault5_b, 1);
    checkOutput("mis_stalls", stall_seen, 0);
    applyStimulus(1, 1, 0, 1, 1, 0, 1, 0, 2'b10, 64'h20, 0, 0, 64'h24);
    checkOutput("mis_nowr_32", z5_a, 32'hAAAA1234);

    applyStimulus(1, 0, 0, 0, 1, 0, 0, 0, 2'b00, 64'h55, 0, 0, 64'h30);
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 1, 2'b00, 64'h30, 64'hFF, 0, 64'h31);
    checkOutput("fwd_sfwd32", sfwd_seen, 64'h55);
    applyStimulus(1, 1, 0, 1, 1, 0, 1, 0, 2'b00, 64'h30, 0, 0, 64'h32);
    checkOutput("fwd_ld32", z5_a, 32'h55);
    checkOutput("fwd_ld64", z5_b, 64'h30);

    applyStimulus(1, 0, 0, 0, 1, 1, 0, 0, 2'b00, 64'h999, 0, 64'h104, 64'h40);
    checkOutput("jal_lit32", z5_a, 32'h104);
    checkOutput("jal_lit64", z5_b, 64'h104);

    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 2'b10, 64'h40, 64'h99887766, 0, 64'h41);
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 2'b10, 64'h40, 64'h11223344, 0, 64'h42, 2);
    applyStimulus(1, 1, 0, 1, 1, 0, 1, 0, 2'b10, 64'h40, 0, 0, 64'h43);
    checkOutput("rst_drop32", z5_a, 32'h99887766);
    checkOutput("rst_drop64", z5_b, 64'h11223344);

    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 2'b11, 64'h08, 64'h0123456789ABCDEF, 0, 64'h50);
    checkOutput("dbl_f5_32", fault5_a, 1);
    applyStimulus(1, 1, 0, 1, 1, 0, 0, 0, 2'b11, 64'h08, 0, 0, 64'h51);
    checkOutput("dbl_lit64", z5_b, 64'h0123456789ABCDEF);
    applyStimulus(1, 1, 0, 1, 1, 0, 0, 0, 2'b11, 64'h0C, 0, 0, 64'h52);
    checkOutput("dbl_mis64", fault5_b, 1);

    for (int i = 0; i < 300; i++) begin
      logic [63:0] z = {$urandom, $urandom};
      if ($urandom_range(0, 1)) z[2:0] = 3'b000;
      applyStimulus($urandom_range(0, 9) != 0, 1'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0,
                    2'($urandom), z, {$urandom, $urandom}, {$urandom, $urandom},
                    {$urandom, $urandom});
    end

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_stage_p.md
# mem_stage_p

Parametrised memory-access pipeline stage for the 32-bit pipelined core, sitting between the execute (stage 4) and write-back (stage 5) registers. It performs byte, halfword, word and optional doubleword loads and stores on an internal little-endian byte-addressed data memory. It adds programmable memory wait states with an upstream stall, sign or zero extension, misalignment detection, and store-data forwarding from the stage-5 result. Stage 4 to stage 5 state is held in a reset-able pipeline register.

## Interface
Parameters:
- DATA_W, 32: datapath width, legal values 32 or 64.
- ADDR_W, 8: byte-address width; the memory holds 2^ADDR_W bytes.
- WAIT_CYC, 0: extra cycles per aligned memory access, 0..15.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- valid4  in  1  stage-4 holds a real instruction.
- ir4, pc4  in  DATA_W  instruction and PC of the stage-4 instruction.
- z4  in  DATA_W  ALU result; the low ADDR_W bits form the byte address.
- s4  in  DATA_W  raw store data.
- mem_to_reg4, mem_read4, mem_write4, reg_write4, jal4  in  1 each  stage-4 controls.
- size4  in  2  access size: 00 byte, 01 half, 10 word, 11 double (double is legal only when DATA_W=64).
- unsigned4  in  1  zero-extend loads when 1, sign-extend when 0.
- fwd_sw_mem  in  1  replace store data with z5.
- s4_fwd  out  DATA_W  effective store data, combinational.
- stall  out  1  upstream must hold all stage-4 inputs this cycle.
- z5, ir5  out  DATA_W  write-back value and instruction.
- reg_write5, valid5, fault5  out  1 each  stage-5 controls and misalignment flag.

## Operation
- s4_fwd = fwd_sw_mem ? z5 : s4.
- An access is valid4 & (mem_read4 | mem_write4).
- If mem_read4 and mem_write4 are both set, the read wins and no write occurs.
- Misaligned access:
  - half with addr[0]=1;
  - word with addr[1:0]≠0;
  - double with addr[2:0]≠0;
  - size 11 when DATA_W=32.
- A misaligned access causes no write and no wait states. Stage 5 then gets fault5=1, reg_write5=0, z5=0.
- Loads: bytes addr..addr+size-1 are assembled little-endian and extended to DATA_W according to unsigned4.
- Stores: the low size bytes of s4_fwd are written. Other bytes are untouched.
- Addresses wrap modulo 2^ADDR_W; upper z4 bits are ignored.
- z5 source:
  - load data if mem_to_reg4;
  - else pc4 if jal4;
  - else z4.
- Wait FSM has two states, IDLE and WAIT, with a 4-bit counter cnt.
  - IDLE, aligned access, WAIT_CYC>0: stall=1, go to WAIT, cnt=WAIT_CYC-1.
  - WAIT, cnt≠0: stall=1, cnt decrements.
  - WAIT, cnt=0: stall=0, the access completes, return to IDLE.
  - With WAIT_CYC=0 the FSM never leaves IDLE.
- Memory contents are not cleared by reset.

## Timing
- Reset (async assert, sync release): z5=0, ir5=0, reg_write5=0, valid5=0, fault5=0, FSM=IDLE, cnt=0.
- Latency:
  - Non-memory and misaligned instructions register into stage 5 at the first clock edge.
  - Aligned accesses register at the edge ending cycle N+WAIT_CYC, where N is the first presentation cycle.
- A store commits at the same completing edge. A load issued in the next cycle sees the new data.
- In every cycle with stall=1, stage 5 loads a bubble: valid5=0, reg_write5=0, fault5=0. z5 and ir5 hold their values, so s4_fwd stays stable.
- Upstream must keep stage-4 inputs constant while stall=1. Changes during a stall are undefined.
- Reset asserted mid-WAIT: the pending store is dropped, and stall drops immediately.
- valid4=0 gives reg_write5=0 and valid5=0. z5 and ir5 are loaded normally.

## Test plan
- WAIT_CYC=0:
  - store word s4=0xDEADBEEF at z4=0x10, then load word at 0x10 next cycle, mem_to_reg4=1 → z5=0xDEADBEEF, reg_write5=1.
  - load byte at 0x13 signed → z5=0xFFFFFFDE; unsigned → 0x000000DE.
- Store half 0x1234 at 0x20 over word 0xAAAAAAAA, then load word → 0xAAAA1234. Half store at 0x21 → fault5=1, reg_write5=0, memory unchanged.
- WAIT_CYC=3, load at cycle N → stall high in cycles N..N+2, three bubbles with valid5=0, z5 valid after the edge ending N+3.
- fwd_sw_mem=1 with z5=0x55 held, store byte at 0x30 → s4_fwd=0x55, and a later load returns 0x55.
- jal4=1, pc4=0x104 → z5=0x104. Assert rst_n=0 mid-WAIT on a store → all outputs 0, stall=0, target bytes unchanged.
- DATA_W=64: double store/load at 0x08 round-trips 0x0123456789ABCDEF. Double access at 0x0C → fault5=1.
